// File: rtl/ariscv_aclk_monitor.sv
// Observer for the ctrlpath local clock strobes: checks strict cyclic stage order and emits per-round period records.
// Latency: stage-0 strobe rise sampled at edge k -> record valid at edge k+2; error flags update on the same edge.
// Backpressure: single-entry record buffer; a record arriving while the buffer is full and not draining is dropped (o_err_ovf).
module ariscv_aclk_monitor #(
   parameter int ACLK_NBW = 6,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ACLK_NBW-1:0]         i_aclk,
   input  logic                        i_en,
   output logic                        o_rec_valid,
   input  logic                        i_rec_ready,
   output logic [CNT_W-1:0]            o_rec_period,
   output logic [CNT_W-1:0]            o_rec_round,
   output logic                        o_busy,
   output logic                        o_err_order,
   output logic [$clog2(ACLK_NBW)-1:0] o_err_stage,
   output logic                        o_err_timeout,
   output logic                        o_err_ovf
);

   localparam int               SW         = $clog2(ACLK_NBW);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [SW-1:0]    LAST_STAGE = SW'(ACLK_NBW - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ACLK_NBW-1:0] s1, s2, s3;
   logic [ACLK_NBW-1:0] edges;
   logic [ACLK_NBW-1:0] exp_mask;
   logic [ACLK_NBW-1:0] unexp;
   logic [SW-1:0]       bad_idx;
   logic [SW-1:0]       exp;
   logic [CNT_W-1:0]    pcnt;
   logic [CNT_W-1:0]    tcnt;
   logic [CNT_W-1:0]    rcnt;
   logic                start;
   logic                accept;
   logic                order_hit;
   logic                timeout_hit;
   logic                round_done;
   logic                rec_take;

   // Two-flop synchronizer plus history flop per strobe for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= i_aclk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edges = s2 & ~s3;

   // Split detected edges into the expected stage and everything else; pick the lowest stray index
   always_comb begin
      exp_mask      = '0;
      exp_mask[exp] = 1'b1;
      unexp         = edges & ~exp_mask;
      bad_idx       = '0;
      for (int i = ACLK_NBW - 1; i >= 0; i--) begin
         if (unexp[i]) bad_idx = SW'(i);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state and per-cycle event decode; stray edges win over a simultaneous expected edge
   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      accept      = 1'b0;
      order_hit   = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_en && edges[0]) begin
               state_nxt = S_RUN;
               start     = 1'b1;
            end
         end
         S_RUN: begin
            if (!i_en) begin
               state_nxt = S_IDLE;
            end else if (|unexp) begin
               order_hit = 1'b1;
               state_nxt = S_ERR;
            end else if (|edges) begin
               accept = 1'b1;
            end else if (tcnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = S_ERR;
            end
         end
         S_ERR: begin
            if (!i_en) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      o_busy = (state == S_RUN);
   end

   assign round_done = accept && (exp == '0);

   // Stage pointer and period/timeout/round counters; frozen in ERR, cleared in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         exp  <= '0;
         pcnt <= '0;
         tcnt <= '0;
         rcnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               exp  <= start ? SW'(1) : '0;
               pcnt <= start ? CNT_W'(1) : '0;
               tcnt <= '0;
               rcnt <= '0;
            end
            S_RUN: begin
               if (accept) begin
                  exp  <= (exp == LAST_STAGE) ? '0 : exp + 1'b1;
                  tcnt <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
               if (round_done) begin
                  pcnt <= CNT_W'(1);
                  rcnt <= rcnt + 1'b1;
               end else if (pcnt != CNT_MAX) begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rec_take = o_rec_valid & i_rec_ready;

   // Single-entry record buffer; overflow when a record closes while the buffer stays occupied
   always_ff @(posedge clk) begin
      if (rst) begin
         o_rec_valid  <= 1'b0;
         o_rec_period <= '0;
         o_rec_round  <= '0;
         o_err_ovf    <= 1'b0;
      end else if (round_done && (!o_rec_valid || i_rec_ready)) begin
         o_rec_valid  <= 1'b1;
         o_rec_period <= pcnt;
         o_rec_round  <= rcnt + 1'b1;
      end else begin
         if (round_done) o_err_ovf   <= 1'b1;
         if (rec_take)   o_rec_valid <= 1'b0;
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         o_err_order   <= 1'b0;
         o_err_stage   <= '0;
         o_err_timeout <= 1'b0;
      end else begin
         if (order_hit) begin
            o_err_order <= 1'b1;
            o_err_stage <= bad_idx;
         end
         if (timeout_hit) o_err_timeout <= 1'b1;
      end
   end

endmodule
